// File: rtl/vedic_mac_4x4.sv
// ---------------------------------------------------------------------------
// vedic_mac_4x4 : two-stage pipelined 4x4 unsigned multiply-accumulate built
// from four 2x2 Vedic (Urdhva-Tiryakbhyam) multipliers.
//
// Parameters
//   ACC_W  accumulator / result width (legal 8..32), default 12
//   CNT_W  beat-counter width, default 8
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   mul_1      in   [3:0] multiplicand
//   mul_2      in   [3:0] multiplier
//   in_first   in   beat starts a new accumulation
//   in_last    in   beat ends the current accumulation
//   in_valid   in   input beat present
//   in_ready   out  input beat accepted this cycle when in_valid=1
//   acc        out  [ACC_W-1:0] running sum including the current output beat
//   product    out  [7:0] product of the current output beat
//   beat_cnt   out  [CNT_W-1:0] beats since the last in_first (saturating)
//   out_last   out  output beat carries in_last
//   out_valid  out  output beat present
//   out_ready  in   downstream accepts the output beat
//
// Handshake: a beat moves across an interface on a rising edge where its
// valid and ready are both 1. valid never depends on ready; in_ready depends
// combinationally on out_ready so the pipe can stream one beat per cycle.
//
// Build option
//   VEDIC_MAC_SAT_EN  defined: accumulation clamps at 2^ACC_W-1 and stays
//                     there until the next in_first beat.
//                     undefined: accumulation wraps modulo 2^ACC_W.
// ---------------------------------------------------------------------------

// 2x2 Vedic multiplier: vertical and crosswise partial products.
module vedic_2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic cross_c;

  always_comb begin
    p_o[0]  = a_i[0] & b_i[0];
    // crosswise terms: their sum is bit 1, their carry feeds bit 2
    p_o[1]  = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
    cross_c = (a_i[1] & b_i[0]) & (a_i[0] & b_i[1]);
    p_o[2]  = (a_i[1] & b_i[1]) ^ cross_c;
    p_o[3]  = (a_i[1] & b_i[1]) & cross_c;
  end
endmodule

module vedic_mac_4x4 #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       mul_1,
  input  logic [3:0]       mul_2,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic [7:0]       product,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  // -------------------------------------------------------------------------
  // Partial products (combinational, registered in stage 1)
  // -------------------------------------------------------------------------
  logic [3:0] pp_ll, pp_lh, pp_hl, pp_hh;

  vedic_2x2 u_pp_ll (.a_i(mul_1[1:0]), .b_i(mul_2[1:0]), .p_o(pp_ll));
  vedic_2x2 u_pp_lh (.a_i(mul_1[1:0]), .b_i(mul_2[3:2]), .p_o(pp_lh));
  vedic_2x2 u_pp_hl (.a_i(mul_1[3:2]), .b_i(mul_2[1:0]), .p_o(pp_hl));
  vedic_2x2 u_pp_hh (.a_i(mul_1[3:2]), .b_i(mul_2[3:2]), .p_o(pp_hh));

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_ll_q, s1_ll_d;
  logic [3:0]       s1_lh_q, s1_lh_d;
  logic [3:0]       s1_hl_q, s1_hl_d;
  logic [3:0]       s1_hh_q, s1_hh_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q, s1_last_d;

  logic             s2_valid_q, s2_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;

  // -------------------------------------------------------------------------
  // Pipeline control
  // -------------------------------------------------------------------------
  logic in_fire;   // beat enters stage 1
  logic s2_load;   // stage 1 beat enters stage 2
  logic out_fire;  // stage 2 beat leaves

  // Stage 1 can take a new beat unless both stages are full and the output
  // is stalled; when stage 2 drains this cycle stage 1 drains into it.
  assign in_ready = ~(s1_valid_q & s2_valid_q & ~out_ready);
  assign in_fire  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
  assign out_fire = s2_valid_q & out_ready;

  // -------------------------------------------------------------------------
  // Stage 2 arithmetic
  // -------------------------------------------------------------------------
  logic [4:0]       mid_sum;   // lh + hl, up to 18
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

`ifdef VEDIC_MAC_SAT_EN
  logic [ACC_W:0]   acc_sum;   // one extra bit to catch the overflow
`endif

  always_comb begin
    mid_sum  = {1'b0, s1_lh_q} + {1'b0, s1_hl_q};
    // hh<<4 + (lh+hl)<<2 + ll ; max 225 so 8 bits never truncate
    prod_d   = {s1_hh_q, 4'b0000} + {1'b0, mid_sum, 2'b00} + {4'b0000, s1_ll_q};
    prod_ext = ACC_W'(prod_d);
    // an in_first beat restarts the sum from zero
    acc_base = s1_first_q ? '0 : acc_q;
`ifdef VEDIC_MAC_SAT_EN
    acc_sum  = {1'b0, acc_base} + {1'b0, prod_ext};
    acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
    acc_next = acc_base + prod_ext;
`endif
    if (s1_first_q) begin
      cnt_next = CNT_W'(1);
    end else if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_next = cnt_q;
    end else begin
      cnt_next = cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state
  // -------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ll_d    = s1_ll_q;
    s1_lh_d    = s1_lh_q;
    s1_hl_d    = s1_hl_q;
    s1_hh_d    = s1_hh_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    acc_d      = acc_q;
    prod_d_hold: begin end
    cnt_d      = cnt_q;
    last_d     = last_q;

    // stage 1: capture a new beat, or empty out when it moved to stage 2
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_ll_d    = pp_ll;
      s1_lh_d    = pp_lh;
      s1_hl_d    = pp_hl;
      s1_hh_d    = pp_hh;
      s1_first_d = in_first;
      s1_last_d  = in_last;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // stage 2: acc and friends change only when a beat enters
    if (s2_load) begin
      s2_valid_d = 1'b1;
      acc_d      = acc_next;
      cnt_d      = cnt_next;
      last_d     = s1_last_q;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  logic [7:0] prod_nq;
  assign prod_nq = s2_load ? prod_d : prod_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_ll_q    <= '0;
      s1_lh_q    <= '0;
      s1_hl_q    <= '0;
      s1_hh_q    <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ll_q    <= s1_ll_d;
      s1_lh_q    <= s1_lh_d;
      s1_hl_q    <= s1_hl_d;
      s1_hh_q    <= s1_hh_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      acc_q      <= acc_d;
      prod_q     <= prod_nq;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
    end
  end

  assign acc       = acc_q;
  assign product   = prod_q;
  assign beat_cnt  = cnt_q;
  assign out_last  = last_q;
  assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_vedic_mac_4x4.sv
// ---------------------------------------------------------------------------
// tb_vedic_mac_4x4 : self-checking bench for vedic_mac_4x4.
// Main DUT uses defaults (ACC_W=12, CNT_W=8); a second instance with ACC_W=8
// covers accumulator overflow. Honours VEDIC_MAC_SAT_EN for expectations.
// ---------------------------------------------------------------------------
module tb_vedic_mac_4x4;
  localparam int ACC_W = 12;
  localparam int CNT_W = 8;
  localparam int W     = 8 + ACC_W + CNT_W + 1;
  localparam int NTBL  = 260;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [3:0]       mul_1, mul_2;
  logic             in_first, in_last, in_valid, in_ready;
  logic [ACC_W-1:0] acc;
  logic [7:0]       product;
  logic [CNT_W-1:0] beat_cnt;
  logic             out_last, out_valid, out_ready;

  vedic_mac_4x4 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .mul_1(mul_1), .mul_2(mul_2),
    .in_first(in_first), .in_last(in_last), .in_valid(in_valid),
    .in_ready(in_ready), .acc(acc), .product(product), .beat_cnt(beat_cnt),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
  );

  // ---------------- 8-bit accumulator DUT ----------------
  logic [3:0] m8_a, m8_b;
  logic       m8_first, m8_last, m8_in_valid, m8_in_ready;
  logic [7:0] m8_acc, m8_product;
  logic [7:0] m8_cnt;
  logic       m8_out_last, m8_out_valid, m8_out_ready;

  vedic_mac_4x4 #(.ACC_W(8), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .mul_1(m8_a), .mul_2(m8_b),
    .in_first(m8_first), .in_last(m8_last), .in_valid(m8_in_valid),
    .in_ready(m8_in_ready), .acc(m8_acc), .product(m8_product),
    .beat_cnt(m8_cnt), .out_last(m8_out_last), .out_valid(m8_out_valid),
    .out_ready(m8_out_ready)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int in_cnt   = 0;
  int out_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  // Transaction level: every accepted beat updates a running sum and count
  // with plain arithmetic; the expected output record is queued in order.
  logic [W-1:0] exp_q[$];
  longint       model_acc;
  longint       model_cnt;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  task automatic model_accept(input logic [3:0] a, input logic [3:0] b,
                              input logic f, input logic l);
    longint p;
    logic [63:0] pv, av, cv;
    p = longint'(a) * longint'(b);
    if (f) model_acc = p;
    else   model_acc = model_acc + p;
`ifdef VEDIC_MAC_SAT_EN
    if (model_acc > ACC_MAX) model_acc = ACC_MAX;
`else
    model_acc = model_acc % (ACC_MAX + 1);
`endif
    if (f)                       model_cnt = 1;
    else if (model_cnt < CNT_MAX) model_cnt = model_cnt + 1;
    pv = p; av = model_acc; cv = model_cnt;
    exp_q.push_back({pv[7:0], av[ACC_W-1:0], cv[CNT_W-1:0], l});
  endtask

  bit               prev_stall = 0;
  logic [7:0]       prev_p;
  logic [ACC_W-1:0] prev_acc;
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_last;

  task automatic flush_model();
    exp_q.delete();
    model_acc  = 0;
    model_cnt  = 0;
    prev_stall = 0;
    in_cnt     = 0;
    out_cnt    = 0;
  endtask

  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_product", product, prev_p);
        check("hold_acc", acc, prev_acc);
        check("hold_cnt", beat_cnt, prev_cnt);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_product", product, mon_e[W-1 -: 8]);
          check("sb_acc", acc, mon_e[W-9 -: ACC_W]);
          check("sb_cnt", beat_cnt, mon_e[CNT_W:1]);
          check("sb_last", out_last, mon_e[0]);
        end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        model_accept(mul_1, mul_2, in_first, in_last);
        in_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = product;
      prev_acc   = acc;
      prev_cnt   = beat_cnt;
      prev_last  = out_last;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] m1;
    logic [3:0] m2;
    logic       first;
    logic       last;
    int         exp_p;
    int         exp_acc;
    int         exp_cnt;
    logic       exp_last;
  } vec_t;

  vec_t tbl[NTBL];

  // Drive one beat into an empty pipe, then wait for and check its output.
  task automatic apply_rec(input int idx, input vec_t r);
    bit got;
    int lat;
    mul_1 = r.m1; mul_2 = r.m2; in_first = r.first; in_last = r.last;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      if (got) break;
    end
    #1 in_valid = 1'b0;
    check($sformatf("tbl_accept[%0d]", idx), got, 1);
    lat = 1;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
      @(posedge clk);
      lat++;
    end
    check($sformatf("tbl_out_seen[%0d]", idx), got, 1);
    check($sformatf("tbl_latency[%0d]", idx), lat, 2);
    check($sformatf("tbl_product[%0d]", idx), product, r.exp_p);
    check($sformatf("tbl_acc[%0d]", idx), acc, r.exp_acc);
    check($sformatf("tbl_cnt[%0d]", idx), beat_cnt, r.exp_cnt);
    check($sformatf("tbl_last[%0d]", idx), out_last, r.exp_last);
    @(posedge clk);
    #1;
  endtask

  task automatic set_rec(input int k, input int a, input int b, input logic f,
                         input logic l, input int ep, input int ea,
                         input int ec, input logic el);
    tbl[k].m1 = 4'(a);  tbl[k].m2 = 4'(b);
    tbl[k].first = f;   tbl[k].last = l;
    tbl[k].exp_p = ep;  tbl[k].exp_acc = ea;
    tbl[k].exp_cnt = ec; tbl[k].exp_last = el;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int sent, stall_acc, out_before;
    bit drop_seen, acc_f, got;

    rst_n = 1'b0;
    mul_1 = '0; mul_2 = '0; in_first = 0; in_last = 0; in_valid = 0;
    out_ready = 1'b1;
    m8_a = '0; m8_b = '0; m8_first = 0; m8_last = 0; m8_in_valid = 0;
    m8_out_ready = 1'b1;
    flush_model();

    // fill the table: exhaustive first+last products, then an accumulation
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        set_rec(a * 16 + b, a, b, 1'b1, 1'b1, a * b, a * b, 1, 1'b1);
    set_rec(256, 3, 3, 1'b1, 1'b0, 9, 9, 1, 1'b0);
    set_rec(257, 2, 5, 1'b0, 1'b0, 10, 19, 2, 1'b0);
    set_rec(258, 15, 15, 1'b0, 1'b1, 225, 244, 3, 1'b1);
    // no in_first after in_last: keeps adding to the held sum
    set_rec(259, 1, 1, 1'b0, 1'b1, 1, 245, 4, 1'b1);

    // reset state
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_product", product, 0);
    check("rst_cnt", beat_cnt, 0);
    check("rst_last", out_last, 0);
    check("rst8_out_valid", m8_out_valid, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven vectors
    for (int i = 0; i < NTBL; i++) apply_rec(i, tbl[i]);

    // overflow on the 8-bit accumulator instance
    m8_a = 4'd15; m8_b = 4'd15; m8_first = 1; m8_last = 0; m8_in_valid = 1;
    @(posedge clk);
    #1 m8_first = 0; m8_last = 1;
    @(posedge clk);
    #1 m8_in_valid = 0; m8_last = 0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m8_out_valid && m8_out_last) begin got = 1; break; end
    end
    check("ovf_seen", got, 1);
    check("ovf_product", m8_product, 225);
`ifdef VEDIC_MAC_SAT_EN
    check("ovf_acc", m8_acc, 255);
`else
    check("ovf_acc", m8_acc, 194);
`endif
    check("ovf_cnt", m8_cnt, 2);
    @(posedge clk);
    #1;

    // backpressure: 4-cycle output stall in the middle of a 12-beat stream
    sent = 0; stall_acc = 0; drop_seen = 0; out_before = out_cnt;
    mul_1 = 4'($urandom_range(0, 15)); mul_2 = 4'($urandom_range(0, 15));
    in_first = 1; in_last = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 4 && c < 8);
      in_valid  = (sent < 12);
      @(negedge clk);
      acc_f = in_valid && in_ready;
      if (!out_ready) begin
        if (!in_ready) drop_seen = 1;
        if (acc_f) stall_acc++;
      end
      @(posedge clk);
      #1;
      if (acc_f) begin
        sent++;
        mul_1 = 4'($urandom_range(0, 15)); mul_2 = 4'($urandom_range(0, 15));
        in_first = 0; in_last = (sent == 11);
      end
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    check("bp_in_ready_dropped", drop_seen, 1);
    check("bp_stall_accepts_le2", stall_acc <= 2, 1);
    check("bp_sent", sent, 12);
    check("bp_out_beats", out_cnt - out_before, 12);
    check("bp_queue_empty", exp_q.size(), 0);

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      mul_1     = 4'($urandom_range(0, 15));
      mul_2     = 4'($urandom_range(0, 15));
      in_first  = ($urandom_range(0, 5) == 0);
      in_last   = ($urandom_range(0, 5) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 0; out_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_queue_empty", exp_q.size(), 0);
    check("rand_in_eq_out", in_cnt, out_cnt);

    // reset with two beats in flight
    out_ready = 1;
    mul_1 = 4'd5; mul_2 = 4'd5; in_first = 1; in_last = 0; in_valid = 1;
    @(posedge clk);
    #1 mul_1 = 4'd3; mul_2 = 4'd7; in_first = 0;
    @(posedge clk);
    #1 in_valid = 0; out_ready = 0;
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_acc", acc, 25);
    #2 rst_n = 1'b0;
    flush_model();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_acc", acc, 0);
    check("mid_rst_cnt", beat_cnt, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    #1 rst_n = 1'b1; out_ready = 1;
    @(posedge clk);
    #1 mul_1 = 4'd2; mul_2 = 4'd2; in_first = 0; in_last = 1; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0; in_last = 0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin got = 1; break; end
    end
    check("post_rst_seen", got, 1);
    check("post_rst_acc", acc, 4);
    check("post_rst_cnt", beat_cnt, 1);
    check("post_rst_last", out_last, 1);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
